// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter with a one-byte holding register.
//
// Frames each byte as start bit, DBIT data bits (LSB first), an optional
// parity bit and SB_TICK s_ticks of stop, all timed from the shared 16x
// oversampling tick. A byte arriving while a frame is on the wire waits in
// the holding register and goes out back-to-back with no idle gap.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   s_tick       16x baud tick, one clk cycle wide
//   tx_start     send request, honoured only while tx_ready = 1
//   tx_data_in   byte to send, sampled on the accepting edge
//   tx_ready     holding register empty
//   tx           registered serial output, idles high
//   tx_done_tick one-cycle pulse on the final stop s_tick of each frame
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, waiting for a byte in the holding reg
// ST_START  | start bit (low) for 16 s_ticks
// ST_DATA   | DBIT data bits, LSB first, 16 s_ticks each
// ST_PARITY | parity bit for 16 s_ticks (PARITY_EN only)
// ST_STOP   | line high for SB_TICK s_ticks
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] tx_data_in,
    output logic            tx_ready,
    output logic            tx,
    output logic            tx_done_tick
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // The tick counter is 5 bits so stop periods longer than one bit fit.
    localparam logic [4:0] S_BIT_LAST  = 5'd15;
    localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST      = 3'(DBIT - 1);
    localparam logic       PAR_INV     = (PARITY_ODD != 0);

    state_t            state_q, state_d;
    logic [4:0]        s_q, s_d;
    logic [2:0]        n_q, n_d;
    logic [DBIT-1:0]   shift_q, shift_d;
    logic [DBIT-1:0]   hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              load;

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        par_d        = par_q;
        tx_d         = tx_q;
        tx_done_tick = 1'b0;
        load         = 1'b0;

        // Accept and load are mutually exclusive: accept needs an empty
        // holding register, load needs a full one.
        if (tx_start && !hold_valid_q) begin
            hold_d       = tx_data_in;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (hold_valid_q) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        tx_d    = shift_q[0];
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        shift_d = shift_q >> 1;
                        if (n_q == N_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx_d    = par_q;
                                state_d = ST_PARITY;
                            end else begin
                                tx_d    = 1'b1;
                                state_d = ST_STOP;
                            end
                        end else begin
                            n_d  = n_q + 3'd1;
                            tx_d = shift_q[1];
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        s_d          = '0;
                        if (hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        // Parity is taken from the byte as loaded, since the shift register
        // is consumed while the data bits go out.
        if (load) begin
            shift_d      = hold_q;
            par_d        = (^hold_q) ^ PAR_INV;
            hold_valid_d = 1'b0;
            s_d          = '0;
            tx_d         = 1'b0;
            state_d      = ST_START;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            n_q          <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            par_q        <= par_d;
            tx_q         <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ~hold_valid_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. Four instances cover 8N1, 8E1, 8O1 and 7 data bits
// with two stop bits. Sent bytes go into a scoreboard queue; a frame monitor
// reconstructs each frame in s_tick units and the test tasks compare it with
// a frame built from the popped byte.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic [3:0] start = 4'b0000;
    logic [7:0] din = 8'h00;
    logic [3:0] rdy;
    logic [3:0] txw;
    logic [3:0] dn;
    logic [1:0] sel = 2'd0;
    logic       mon_tx, mon_done, mon_rdy;
    int         tick_ph = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(start[0]), .tx_data_in(din),
        .tx_ready(rdy[0]), .tx(txw[0]), .tx_done_tick(dn[0]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(start[1]), .tx_data_in(din),
        .tx_ready(rdy[1]), .tx(txw[1]), .tx_done_tick(dn[1]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(start[2]), .tx_data_in(din),
        .tx_ready(rdy[2]), .tx(txw[2]), .tx_done_tick(dn[2]));
    uart_tx #(.DBIT(7), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_7n2 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(start[3]), .tx_data_in(din[6:0]),
        .tx_ready(rdy[3]), .tx(txw[3]), .tx_done_tick(dn[3]));

    assign mon_tx   = txw[sel];
    assign mon_done = dn[sel];
    assign mon_rdy  = rdy[sel];

    always #5 clk = ~clk;

    // s_tick every 4 clk, changed on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            tick_ph = (tick_ph + 1) % 4;
            s_tick  = (tick_ph == 0);
        end
    end

    function automatic logic [15:0] make_frame(input logic [7:0] d, input int dbit,
                                               input bit pen, input bit podd);
        logic [15:0] f;
        logic        p;
        f = '0;
        p = podd;
        for (int i = 0; i < dbit; i++) begin
            f[1+i] = d[i];
            p      = p ^ d[i];
        end
        if (pen) begin
            f[dbit+1] = p;
            f[dbit+2] = 1'b1;
        end else begin
            f[dbit+1] = 1'b1;
        end
        return f;
    endfunction

    task automatic send(input logic [1:0] which, input logic [7:0] d, input bit expect_acc);
        @(negedge clk);
        start[which] = 1'b1;
        din          = d;
        if (expect_acc) exp_q.push_back(d);
        @(negedge clk);
        start[which] = 1'b0;
    endtask

    // Samples once per cycle just after the falling edge. nbits counts start,
    // data and parity bits; bits[nbits] holds the observed stop level.
    task automatic capture(input int nbits, input int sbt, input int max_wait,
                           output logic [15:0] bits, output int waited, output int bad,
                           output int done_at, output int done_cnt);
        int ticks, idx, cur, guard, total;
        bits = '0; waited = 0; bad = 0; done_at = -1; done_cnt = 0;
        total = nbits * 16 + sbt; cur = -1; guard = 0; ticks = 0;
        @(negedge clk); #1;
        while (mon_tx !== 1'b0) begin
            if (waited >= max_wait) begin
                waited = -1;
                return;
            end
            waited++;
            @(negedge clk); #1;
        end
        while (ticks < total && guard < total * 8) begin
            if (guard > 0) begin
                @(negedge clk); #1;
            end
            idx = (ticks < nbits * 16) ? ticks / 16 : nbits;
            if (idx != cur) begin
                bits[idx] = mon_tx;
                cur       = idx;
            end else if (mon_tx !== bits[idx]) begin
                bad++;
            end
            if (mon_done === 1'b1) begin
                done_cnt++;
                done_at = ticks + 1;
            end
            if (s_tick === 1'b1) ticks++;
            guard++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (txw !== 4'hF) begin n_err++; $display("FAIL reset_tx got=%b exp=1111", txw); end
        n_cmp++; if (rdy !== 4'hF) begin n_err++; $display("FAIL reset_ready got=%b exp=1111", rdy); end
        n_cmp++; if (dn !== 4'h0) begin n_err++; $display("FAIL reset_done got=%b exp=0000", dn); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        logic [15:0] bits; int waited, bad, done_at, done_cnt; logic [7:0] e;
        sel = 2'd0;
        fork
            send(2'd0, 8'h55, 1'b1);
            capture(9, 16, 10, bits, waited, bad, done_at, done_cnt);
            begin
                @(negedge clk); @(negedge clk); #1;
                n_cmp++; if (mon_rdy !== 1'b0) begin n_err++; $display("FAIL 8n1_ready_after_accept got=%b exp=0", mon_rdy); end
                @(negedge clk); #1;
                n_cmp++; if (mon_rdy !== 1'b1) begin n_err++; $display("FAIL 8n1_ready_after_load got=%b exp=1", mon_rdy); end
            end
        join
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++; if (waited !== 2) begin n_err++; $display("FAIL 8n1_start_latency got=%0d exp=2", waited); end
        n_cmp++; if (bits !== make_frame(e, 8, 1'b0, 1'b0)) begin n_err++; $display("FAIL 8n1_frame got=%b exp=%b", bits, make_frame(e, 8, 1'b0, 1'b0)); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL 8n1_bit_width glitches=%0d exp=0", bad); end
        n_cmp++; if (done_at !== 160) begin n_err++; $display("FAIL 8n1_done_tick got=%0d exp=160", done_at); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL 8n1_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] b1, b2; int w1, w2, bad1, bad2, d1, d2, c1, c2, extra; logic [7:0] e1, e2;
        sel = 2'd0;
        fork
            begin
                capture(9, 16, 10, b1, w1, bad1, d1, c1);
                capture(9, 16, 2, b2, w2, bad2, d2, c2);
            end
            begin
                send(2'd0, 8'hA3, 1'b1);
                repeat (150) @(negedge clk);
                #1;
                n_cmp++; if (mon_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_ready_mid_frame got=%b exp=1", mon_rdy); end
                send(2'd0, 8'h0F, 1'b1);
                #1;
                n_cmp++; if (mon_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_ready_after_second got=%b exp=0", mon_rdy); end
                repeat (20) @(negedge clk);
                send(2'd0, 8'hFF, 1'b0);
                #1;
                n_cmp++; if (mon_rdy !== 1'b0) begin n_err++; $display("FAIL ignored_ready got=%b exp=0", mon_rdy); end
            end
        join
        e1 = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        e2 = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++; if (b1 !== make_frame(e1, 8, 1'b0, 1'b0)) begin n_err++; $display("FAIL b2b_frame1 got=%b exp=%b", b1, make_frame(e1, 8, 1'b0, 1'b0)); end
        n_cmp++; if (d1 !== 160 || c1 !== 1) begin n_err++; $display("FAIL b2b_done1 at=%0d cnt=%0d exp at=160 cnt=1", d1, c1); end
        n_cmp++; if (w2 !== 0) begin n_err++; $display("FAIL b2b_idle_gap got=%0d exp=0", w2); end
        n_cmp++; if (b2 !== make_frame(e2, 8, 1'b0, 1'b0)) begin n_err++; $display("FAIL b2b_frame2 got=%b exp=%b", b2, make_frame(e2, 8, 1'b0, 1'b0)); end
        n_cmp++; if (d2 !== 160 || c2 !== 1) begin n_err++; $display("FAIL b2b_done2 at=%0d cnt=%0d exp at=160 cnt=1", d2, c2); end
        n_cmp++; if (bad1 + bad2 !== 0) begin n_err++; $display("FAIL b2b_bit_width glitches=%0d exp=0", bad1 + bad2); end
        extra = 0;
        repeat (700) begin
            @(negedge clk); #1;
            if (mon_tx !== 1'b1 || mon_done !== 1'b0) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ignored_not_sent activity=%0d exp=0", extra); end
    endtask

    task automatic test_parity();
        logic [15:0] bits; int waited, bad, done_at, done_cnt; logic [7:0] e;
        for (int k = 1; k <= 2; k++) begin
            sel = 2'(k);
            fork
                send(2'(k), 8'h07, 1'b1);
                capture(10, 16, 10, bits, waited, bad, done_at, done_cnt);
            join
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (bits !== make_frame(e, 8, 1'b1, k == 2)) begin n_err++; $display("FAIL parity%0d_frame got=%b exp=%b", k, bits, make_frame(e, 8, 1'b1, k == 2)); end
            n_cmp++; if (bits[9] !== ((k == 1) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL parity%0d_bit got=%b exp=%b", k, bits[9], (k == 1) ? 1'b1 : 1'b0); end
            n_cmp++; if (done_at !== 176 || done_cnt !== 1) begin n_err++; $display("FAIL parity%0d_done at=%0d cnt=%0d exp at=176 cnt=1", k, done_at, done_cnt); end
            n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL parity%0d_bit_width glitches=%0d exp=0", k, bad); end
        end
    endtask

    task automatic test_stop_len();
        logic [15:0] bits; int waited, bad, done_at, done_cnt; logic [7:0] e;
        sel = 2'd3;
        fork
            send(2'd3, 8'h7F, 1'b1);
            capture(8, 32, 10, bits, waited, bad, done_at, done_cnt);
        join
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++; if (bits !== make_frame(e, 7, 1'b0, 1'b0)) begin n_err++; $display("FAIL stop_frame got=%b exp=%b", bits, make_frame(e, 7, 1'b0, 1'b0)); end
        n_cmp++; if (done_at !== 160 || done_cnt !== 1) begin n_err++; $display("FAIL stop_done at=%0d cnt=%0d exp at=160 cnt=1", done_at, done_cnt); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stop_width glitches=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid_frame();
        int extra;
        sel = 2'd0;
        send(2'd0, 8'hC3, 1'b1);
        repeat (150) @(negedge clk);
        send(2'd0, 8'h3C, 1'b1);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mon_tx !== 1'b1) begin n_err++; $display("FAIL midreset_tx got=%b exp=1", mon_tx); end
        n_cmp++; if (mon_rdy !== 1'b1) begin n_err++; $display("FAIL midreset_ready got=%b exp=1", mon_rdy); end
        n_cmp++; if (mon_done !== 1'b0) begin n_err++; $display("FAIL midreset_done got=%b exp=0", mon_done); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        extra = 0;
        repeat (800) begin
            @(negedge clk); #1;
            if (mon_tx !== 1'b1 || mon_done !== 1'b0) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL midreset_residual activity=%0d exp=0", extra); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_back_to_back();
        test_parity();
        test_stop_len();
        test_reset_mid_frame();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
